mm_stream: RTL

Parametrised streaming signed matrix multiplier: C(n×p) = A(n×m) · B(m×p), with all dimensions from 1 to MAX_DIM. Both operands arrive row-major on one element-wide input stream. Results leave row-major on a valid/ready output stream. It generalises the fixed 4×4 multiplier with configurable width and depth, input qualification, output backpressure, shape checking and a last-beat flag.

---
 rtl/mm_stream_pkg.sv | 21 ++
 rtl/mm_dot_unit.sv | 63 ++++++
 rtl/mm_stream.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mm_stream_pkg.sv
// Shared types and width helpers for the streaming matrix multiplier.
// Holds the FSM state enum and the index/result width derivations.
package mm_stream_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    CHECK,
    COMPUTE,
    ERROR
  } state_t;

  function automatic int idx_w(input int md);
    return (md > 1) ? $clog2(md) : 1;
  endfunction

  function automatic int out_w(input int dw, input int md);
    return 2 * dw + idx_w(md);
  endfunction

endpackage

// File: rtl/mm_dot_unit.sv
// Masked dot product: MAX_DIM multiplier lanes, product register, adder, sum register.
// Ports: clk, rst, i_en (shared stage enable), i_mask, i_a, i_b, o_sum. Macro: MM_UNSIGNED_EN.
module mm_dot_unit
  import mm_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 4,
  parameter int OUT_WIDTH  = out_w(DATA_WIDTH, MAX_DIM)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_en,
  input  logic [MAX_DIM-1:0]                   i_mask,
  input  logic [MAX_DIM-1:0][DATA_WIDTH-1:0]   i_a,
  input  logic [MAX_DIM-1:0][DATA_WIDTH-1:0]   i_b,
  output logic [OUT_WIDTH-1:0]                 o_sum
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int XW = OUT_WIDTH - PW;

  logic [MAX_DIM-1:0][PW-1:0] w_prod;
  logic [MAX_DIM-1:0][PW-1:0] r_prod;
  logic [OUT_WIDTH-1:0]       w_sum;
  logic [OUT_WIDTH-1:0]       r_sum;

  always_comb begin
    for (int k = 0; k < MAX_DIM; k++) begin
      w_prod[k] = '0;
      if (i_mask[k]) begin
`ifdef MM_UNSIGNED_EN
        w_prod[k] = PW'(i_a[k]) * PW'(i_b[k]);
`else
        w_prod[k] = PW'($signed(i_a[k])) * PW'($signed(i_b[k]));
`endif
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < MAX_DIM; k++) begin
`ifdef MM_UNSIGNED_EN
      w_sum = w_sum + {{XW{1'b0}}, r_prod[k]};
`else
      w_sum = w_sum + {{XW{r_prod[k][PW-1]}}, r_prod[k]};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
      r_sum  <= '0;
    end else if (i_en) begin
      r_prod <= w_prod;
      r_sum  <= w_sum;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/mm_stream.sv
// Streaming matrix multiplier C = A*B: loads A then B row-major, checks shapes, streams C.
// Ports: in_valid/in_data/col_end/row_end in, busy, out_* valid/ready stream. Macro: MM_UNSIGNED_EN.
module mm_stream
  import mm_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_DIM    = 4,
  localparam int OUT_WIDTH  = out_w(DATA_WIDTH, MAX_DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  col_end,
  input  logic                  row_end,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  is_legal,
  output logic                  change_row,
  output logic                  out_last
);

  localparam int IW = idx_w(MAX_DIM);
  localparam int CW = IW + 1;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t MAXC = cnt_t'(MAX_DIM);
  localparam cnt_t ONE  = cnt_t'(1);

  state_t r_state;
  state_t w_next;

  cnt_t r_row;
  cnt_t r_col;
  cnt_t r_rows_a;
  cnt_t r_cols_a;
  cnt_t r_rows_b;
  cnt_t r_cols_b;
  logic r_err;

  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic          r_idone;

  logic r_v1;
  logic r_cr1;
  logic r_l1;
  logic r_v2;
  logic r_cr2;
  logic r_l2;

  logic [DATA_WIDTH-1:0] r_a [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] r_b [MAX_DIM][MAX_DIM];

  logic w_load;
  logic w_acc;
  logic w_ce;
  logic w_inb;
  logic w_legal;
  logic w_err_st;
  logic w_en;
  logic w_issue;
  logic w_jlast;
  logic w_ilast;
  cnt_t w_width;
  cnt_t w_cols_cur;

  logic [MAX_DIM-1:0]                 w_mask;
  logic [MAX_DIM-1:0][DATA_WIDTH-1:0] w_avec;
  logic [MAX_DIM-1:0][DATA_WIDTH-1:0] w_bvec;
  logic [OUT_WIDTH-1:0]               w_sum;

  assign w_load     = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign busy       = !w_load;
  assign w_acc      = in_valid && w_load;
  assign w_ce       = col_end || row_end;
  assign w_width    = r_col + ONE;
  assign w_cols_cur = (r_state == LOAD_B) ? r_cols_b : r_cols_a;
  // Out-of-range beats are flagged and never written to storage.
  assign w_inb      = (r_row < MAXC) && (r_col < MAXC);
  assign w_legal    = !r_err && (r_cols_a == r_rows_b);
  assign w_err_st   = (r_state == ERROR);

  assign out_valid  = r_v2 || w_err_st;
  assign w_en       = !out_valid || out_ready;
  assign w_jlast    = ({1'b0, r_j} + ONE) == r_cols_b;
  assign w_ilast    = ({1'b0, r_i} + ONE) == r_rows_a;
  assign w_issue    = (r_state == COMPUTE) && !r_idone && w_en;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD_A:  if (w_acc && row_end) w_next = LOAD_B;
      LOAD_B:  if (w_acc && row_end) w_next = CHECK;
      CHECK:   w_next = w_legal ? COMPUTE : ERROR;
      COMPUTE: if (r_v2 && r_l2 && out_ready) w_next = LOAD_A;
      ERROR:   if (out_ready) w_next = LOAD_A;
      default: w_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= LOAD_A;
      r_row    <= '0;
      r_col    <= '0;
      r_rows_a <= '0;
      r_cols_a <= '0;
      r_rows_b <= '0;
      r_cols_b <= '0;
      r_err    <= 1'b0;
      r_i      <= '0;
      r_j      <= '0;
      r_idone  <= 1'b0;
      r_v1     <= 1'b0;
      r_cr1    <= 1'b0;
      r_l1     <= 1'b0;
      r_v2     <= 1'b0;
      r_cr2    <= 1'b0;
      r_l2     <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_acc) begin
        if (!w_inb) r_err <= 1'b1;
        // The first row fixes the width; later rows must match it.
        if (w_ce) begin
          if (r_row == '0) begin
            if (r_state == LOAD_B) r_cols_b <= w_width;
            else                   r_cols_a <= w_width;
          end else if (w_width != w_cols_cur) begin
            r_err <= 1'b1;
          end
        end
        if (row_end) begin
          r_row <= '0;
          r_col <= '0;
          if (r_state == LOAD_B) r_rows_b <= r_row + ONE;
          else                   r_rows_a <= r_row + ONE;
        end else if (col_end) begin
          r_col <= '0;
          if (r_row < MAXC) r_row <= r_row + ONE;
        end else if (r_col < MAXC) begin
          r_col <= r_col + ONE;
        end
      end

      if (r_state == CHECK) begin
        r_err   <= 1'b0;
        r_i     <= '0;
        r_j     <= '0;
        r_idone <= 1'b0;
      end

      if (w_issue) begin
        if (w_jlast) begin
          r_j <= '0;
          if (w_ilast) r_idone <= 1'b1;
          else         r_i <= r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end

      // Flags travel with the data through the two dot-unit stages.
      if (w_en) begin
        r_v1  <= w_issue;
        r_cr1 <= w_jlast;
        r_l1  <= w_jlast && w_ilast;
        r_v2  <= r_v1;
        r_cr2 <= r_cr1;
        r_l2  <= r_l1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && w_inb) begin
      if (r_state == LOAD_A) r_a[r_row[IW-1:0]][r_col[IW-1:0]] <= in_data;
      else                   r_b[r_row[IW-1:0]][r_col[IW-1:0]] <= in_data;
    end
  end

  // Lanes beyond A_cols are masked, so stale storage never contributes.
  always_comb begin
    for (int k = 0; k < MAX_DIM; k++) begin
      w_avec[k] = r_a[r_i][k];
      w_bvec[k] = r_b[k][r_j];
      w_mask[k] = cnt_t'(k) < r_cols_a;
    end
  end

  mm_dot_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DIM    (MAX_DIM),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_dot (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en),
    .i_mask (w_mask),
    .i_a    (w_avec),
    .i_b    (w_bvec),
    .o_sum  (w_sum)
  );

  assign out_data   = w_err_st ? '0 : w_sum;
  assign is_legal   = !w_err_st;
  assign change_row = r_v2 && r_cr2 && !w_err_st;
  assign out_last   = (r_v2 && r_l2) || w_err_st;

endmodule
